// File: rtl/row_fetch_sched.sv
// Row fetch sequencer: reads PER_LINE values per text row, converts each to 3 BCD digits
// and commits the assembled row to lineout. Optional macro ROW_OOR_BLANK_EN blanks slots past L.
module row_fetch_sched #(
  parameter int unsigned HCHAR    = 48,
  parameter int unsigned VCHAR    = 18,
  parameter int unsigned L        = 47,
  parameter int unsigned N        = 10,
  parameter int unsigned ADR_BITS = 6,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 row_start,
  input  logic [4:0]           row_idx,
  input  logic [2:0]           pagenum,
  output logic                 rd_en,
  output logic [ADR_BITS-1:0]  rd_addr,
  input  logic [N-1:0]         rd_data,
  output logic [4*HCHAR-1:0]   lineout,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int unsigned PER_LINE = HCHAR / 3;
  localparam int unsigned LINEBITS = 4 * HCHAR;
  localparam int unsigned SlotW    = $clog2(PER_LINE);
  localparam logic [SlotW-1:0] LastSlot = SlotW'(PER_LINE - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StCommit} state_e;

  state_e                         state_q, state_d;
  logic [4:0]                     row_q;
  logic [2:0]                     page_q;
  logic [SlotW-1:0]               slot_q;
  logic                           overrun_q;
  logic [RD_LAT-1:0]              pipe_vld_q, pipe_blank_q;
  logic [RD_LAT-1:0][SlotW-1:0]   pipe_slot_q;
  logic [PER_LINE-1:0][11:0]      back_buf_q;
  logic [LINEBITS-1:0]            lineout_q;
  logic [11:0]                    idx;
  logic                           slot_blank;
  logic                           exit_vld;
  logic [SlotW-1:0]               exit_slot;

  function automatic logic [11:0] to_bcd(input logic [N-1:0] v);
    int unsigned u;
    u = 32'(v);
    if (u > 999) return 12'h999;
    return {4'(u / 100), 4'((u / 10) % 10), 4'(u % 10)};
  endfunction

  // 12-bit index cannot overflow: max page/row/slot gives 2527
  assign idx = 12'(page_q) * 12'(VCHAR * PER_LINE) + 12'(row_q) * 12'(PER_LINE) + 12'(slot_q);

`ifdef ROW_OOR_BLANK_EN
  assign slot_blank = (idx >= 12'(L));
`else
  assign slot_blank = 1'b0;
`endif

  assign exit_vld  = pipe_vld_q[RD_LAT-1];
  assign exit_slot = pipe_slot_q[RD_LAT-1];
  assign lineout   = lineout_q;
  assign overrun   = overrun_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (row_start) state_d = StIssue;
      StIssue: begin
        if (row_start)               state_d = StIssue;
        else if (slot_q == LastSlot) state_d = StDrain;
      end
      StDrain: begin
        if (row_start)                                 state_d = StIssue;
        else if (exit_vld && (exit_slot == LastSlot))  state_d = StCommit;
      end
      StCommit: state_d = row_start ? StIssue : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: ;
      StIssue: begin
        rd_en   = !slot_blank;
        rd_addr = ADR_BITS'(idx);
        busy    = 1'b1;
      end
      StDrain:  busy = 1'b1;
      StCommit: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Tag pipe mirrors RAM latency; any row_start flushes in-flight tags
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pipe_vld_q   <= '0;
      pipe_blank_q <= '0;
      pipe_slot_q  <= '0;
    end else if (row_start) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0]   <= (state_q == StIssue);
      pipe_blank_q[0] <= slot_blank;
      pipe_slot_q[0]  <= slot_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]   <= pipe_vld_q[i-1];
        pipe_blank_q[i] <= pipe_blank_q[i-1];
        pipe_slot_q[i]  <= pipe_slot_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      row_q      <= '0;
      page_q     <= '0;
      slot_q     <= '0;
      overrun_q  <= 1'b0;
      back_buf_q <= '0;
      lineout_q  <= '0;
    end else begin
      overrun_q <= row_start && ((state_q == StIssue) || (state_q == StDrain));
      if (row_start) begin
        row_q  <= row_idx;
        page_q <= pagenum;
        slot_q <= '0;
      end else if (state_q == StIssue) begin
        slot_q <= slot_q + 1'b1;
      end
      // Slot 0 lives in the most significant 12 bits
      if (exit_vld) begin
        back_buf_q[LastSlot - exit_slot] <= pipe_blank_q[RD_LAT-1] ? 12'hFFF : to_bcd(rd_data);
      end
      if (state_q == StCommit) lineout_q <= LINEBITS'(back_buf_q);
    end
  end

endmodule

// File: tb/tb_row_fetch_sched.sv
// Bench for row_fetch_sched: RD_LAT=1 and RD_LAT=3 instances driven in lockstep, checked
// against a per-row model of the expected line contents and cycle timing.
module tb_row_fetch_sched;

`ifdef ROW_OOR_BLANK_EN
  localparam bit BlankEn = 1'b1;
`else
  localparam bit BlankEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         RST;
  logic         row_start;
  logic [4:0]   row_idx;
  logic [2:0]   pagenum;
  logic         rd_en1, rd_en3, busy1, busy3, done1, done3, ovr1, ovr3;
  logic [5:0]   rd_addr1, rd_addr3;
  logic [9:0]   d1, d3a, d3b, d3c;
  logic [191:0] lineout1, lineout3;

  logic [9:0]   mem [64];
  int           n_assert = 0;
  int           n_fail = 0;

  logic [63:0]  l_busy, l_done1, l_done3, l_ovr, l_rden, l_zero;
  logic [5:0]   l_addr [64];

  always #5 clk = ~clk;

  row_fetch_sched #(.RD_LAT(1)) dut1 (
    .clk(clk), .RST(RST), .row_start(row_start), .row_idx(row_idx), .pagenum(pagenum),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(d1), .lineout(lineout1),
    .busy(busy1), .done(done1), .overrun(ovr1)
  );

  row_fetch_sched #(.RD_LAT(3)) dut3 (
    .clk(clk), .RST(RST), .row_start(row_start), .row_idx(row_idx), .pagenum(pagenum),
    .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(d3c), .lineout(lineout3),
    .busy(busy3), .done(done3), .overrun(ovr3)
  );

  // RAM models; unread cycles return noise so stray captures show up
  always @(posedge clk) begin
    d1  <= rd_en1 ? mem[rd_addr1] : 10'($urandom);
    d3a <= rd_en3 ? mem[rd_addr3] : 10'($urandom);
    d3b <= d3a;
    d3c <= d3b;
  end

  function automatic logic [11:0] dec3(input logic [9:0] v);
    int u, h, t;
    logic [31:0] hv, tv, uv;
    u = int'(v);
    if (u > 999) u = 999;
    h = 0;
    t = 0;
    while (u >= 100) begin u -= 100; h++; end
    while (u >= 10) begin u -= 10; t++; end
    hv = h; tv = t; uv = u;
    return {hv[3:0], tv[3:0], uv[3:0]};
  endfunction

  function automatic logic [191:0] model_line(input int row, input int page);
    logic [191:0] line;
    logic [11:0]  code;
    int           idx;
    line = '0;
    for (int s = 0; s < 16; s++) begin
      idx = page * 288 + row * 16 + s;
      if (BlankEn && idx >= 47) code = 12'hFFF;
      else code = dec3(mem[idx % 64]);
      line[191 - 12 * s -: 12] = code;
    end
    return line;
  endfunction

  function automatic int first_set(input logic [63:0] v);
    for (int i = 0; i < 64; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse row_start, then log n cycles; optional second pulse and reset window
  task automatic launch(input int row, input int page, input int n,
                        input int row2_at, input int row2, input int page2, input int rst_at);
    l_busy = '0; l_done1 = '0; l_done3 = '0; l_ovr = '0; l_rden = '0; l_zero = '0;
    for (int i = 0; i < 64; i++) l_addr[i] = '0;
    @(posedge clk); #1;
    row_start = 1'b1;
    row_idx   = 5'(row);
    pagenum   = 3'(page);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      row_start = 1'b0;
      if (k == row2_at) begin
        row_start = 1'b1;
        row_idx   = 5'(row2);
        pagenum   = 3'(page2);
      end
      if (k == rst_at) RST = 1'b1;
      if (k == rst_at + 2) RST = 1'b0;
      @(negedge clk);
      l_busy[k]  = busy1;
      l_done1[k] = done1;
      l_done3[k] = done3;
      l_ovr[k]   = ovr1;
      l_rden[k]  = rd_en1;
      l_addr[k]  = rd_addr1;
      l_zero[k]  = !rd_en1 && rd_addr1 == 0 && lineout1 == 0 && !busy1 && !done1 && !ovr1 &&
                   !rd_en3 && rd_addr3 == 0 && lineout3 == 0 && !busy3 && !done3 && !ovr3;
    end
  endtask

  initial begin
    logic [191:0] exp_line;
    RST = 1'b1;
    row_start = 1'b0;
    row_idx = '0;
    pagenum = '0;
    for (int a = 0; a < 64; a++) mem[a] = 10'((3 * a) % 1024);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl1", {rd_en1, rd_addr1, busy1, done1, ovr1}, '0);
    chk("reset_ctl3", {rd_en3, rd_addr3, busy3, done3, ovr3}, '0);
    chk("reset_line1", lineout1, '0);
    chk("reset_line3", lineout3, '0);
    @(posedge clk); #1;
    RST = 1'b0;

    // Row 0 page 0
    launch(0, 0, 22, 100, 0, 0, 100);
    chk("s1_done_at", 192'(first_set(l_done1)), 192'(18));
    chk("s1_done_cnt", 192'($countones(l_done1)), 192'(1));
    chk("s1_busy", 192'(l_busy), 192'(64'h7_FFFE));
    chk("s1_rden", 192'(l_rden), 192'(64'h1_FFFE));
    chk("s1_slot0", 192'(lineout1[191:180]), 192'(12'h000));
    chk("s1_slot5", 192'(lineout1[131:120]), 192'(12'h015));
    chk("s1_line", lineout1, model_line(0, 0));
    chk("s6_done_at", 192'(first_set(l_done3)), 192'(20));
    chk("s6_line", lineout3, model_line(0, 0));

    // Row 2 page 0: crosses the L boundary at slot 15
    launch(2, 0, 22, 100, 0, 0, 100);
    chk("s2_addr1", 192'(l_addr[1]), 192'(32));
    chk("s2_addr16", 192'(l_addr[16]), 192'(47));
    chk("s2_rden16", 192'(l_rden[16]), 192'(!BlankEn));
    chk("s2_slot14", 192'(lineout1[23:12]), 192'(12'h138));
    chk("s2_slot15", 192'(lineout1[11:0]), 192'(BlankEn ? 12'hFFF : 12'h141));
    chk("s2_line1", lineout1, model_line(2, 0));
    chk("s2_line3", lineout3, model_line(2, 0));

    // Saturation
    for (int a = 0; a < 64; a++) mem[a] = 10'd1023;
    launch(0, 0, 22, 100, 0, 0, 100);
    chk("s3_line1", lineout1, {16{12'h999}});
    chk("s3_line3", lineout3, {16{12'h999}});
    for (int a = 0; a < 64; a++) mem[a] = 10'((3 * a) % 1024);

    // Overrun: row 1 aborted by row 3 at T+6
    launch(1, 0, 30, 6, 3, 0, 100);
    chk("s4_ovr", 192'(l_ovr), 192'(64'h80));
    chk("s4_done_at", 192'(first_set(l_done1)), 192'(24));
    chk("s4_done_cnt", 192'($countones(l_done1)), 192'(1));
    chk("s4_done3", 192'(l_done3), 192'(64'h1 << 26));
    chk("s4_slot0", 192'(lineout1[191:180]), 192'(12'h144));
    chk("s4_line1", lineout1, model_line(3, 0));
    chk("s4_line3", lineout3, model_line(3, 0));

    // row_start in the commit cycle (dut1); same pulse aborts dut3 while draining
    launch(5, 1, 40, 18, 6, 2, 100);
    chk("cc_ovr", 192'(l_ovr), 192'(0));
    chk("cc_done1", 192'(l_done1), 192'((64'h1 << 18) | (64'h1 << 36)));
    chk("cc_done3", 192'(l_done3), 192'(64'h1 << 38));
    chk("cc_line1", lineout1, model_line(6, 2));
    chk("cc_line3", lineout3, model_line(6, 2));

    // Reset mid-fetch, then a clean fetch
    launch(7, 0, 30, 100, 0, 0, 9);
    chk("s5_zero", 192'(l_zero[9]), 192'(1));
    chk("s5_no_done", 192'($countones(l_done1) + $countones(l_done3)), 192'(0));
    launch(4, 1, 22, 100, 0, 0, 100);
    chk("s5_done_at", 192'(first_set(l_done1)), 192'(18));
    chk("s5_line1", lineout1, model_line(4, 1));
    chk("s5_line3", lineout3, model_line(4, 1));

    // Random RAM contents and row/page selection
    for (int it = 0; it < 6; it++) begin
      int r, p;
      for (int a = 0; a < 64; a++) mem[a] = 10'($urandom_range(0, 1023));
      r = int'($urandom_range(0, 17));
      p = int'($urandom_range(0, 7));
      launch(r, p, 22, 100, 0, 0, 100);
      exp_line = model_line(r, p);
      chk("rnd_done_at", 192'(first_set(l_done1)), 192'(18));
      chk("rnd_line1", lineout1, exp_line);
      chk("rnd_line3", lineout3, exp_line);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
